fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  IF stage of the 5-stage pipeline, directly upstream of the hazard unit: owns the PC and the IF/ID latch.
//  Resolves next PC from the EX-stage pc_select/z_fl and holds a redirect that arrives while fetch is stalled.
//  Drives imemREN/imemaddr to the cache. Obeys pc_enable, ifid_enable and ifid_flush from the hazard unit.
// PARAMETERS
//  PC_INIT   32'h0000_0000  PC value loaded on reset
// PORTS
//  CLK            in   1   clock, rising edge
//  nRST           in   1   asynchronous active-low reset
//  ihit           in   1   instruction cache hit this cycle
//  imemload       in   32  instruction word from icache
//  pc_enable      in   1   hazard unit: PC may advance/redirect
//  ifid_enable    in   1   hazard unit: IF/ID latch captures
//  ifid_flush     in   1   hazard unit: IF/ID latch clears (beats enable)
//  pc_select      in   3   EX-stage pc_select (cpu_types_pkg: NEXT, JUMP, JUMPREGISTER, BRANCH_IF_EQUAL, BRANCH_IF_NOT_EQUAL)
//  z_fl           in   1   EX-stage ALU zero flag
//  ex_npc         in   32  PC+4 of the EX-stage instruction
//  ex_imm16       in   16  EX-stage immediate (branch offset, in words)
//  ex_jaddr       in   26  EX-stage J-type target field
//  ex_rs_data     in   32  forwarded rs value for JR
//  halt           in   1   HALT has retired; stop fetching
//  imemREN        out  1   icache read enable
//  imemaddr       out  32  current PC
//  ifid_imemload  out  32  IF/ID instruction
//  ifid_npc       out  32  IF/ID PC+4
// BEHAVIOUR
//  Reset (async, nRST=0): pc=PC_INIT, state=RUN, pend_target=0, ifid_imemload=0, ifid_npc=0; imemREN=1 from first cycle after release.
//  take = JUMP | JUMPREGISTER | (BEQ & z_fl) | (BNE & !z_fl); identical to the hazard unit condition.
//  target: JUMP -> {ex_npc[31:28], ex_jaddr, 2'b00}; JR -> ex_rs_data;
//    BEQ/BNE -> ex_npc + {{14{ex_imm16[15]}}, ex_imm16, 2'b00}, mod 2^32; no overflow detection.
//  imemaddr = pc (combinational). imemREN = (state != HALTED).
//  FSM states RUN, PEND, HALTED; all state and pc updates at posedge CLK:
//   RUN:  halt -> HALTED (pc frozen).
//         else take & pc_enable -> pc=target.
//         else take & !pc_enable -> pend_target=target, PEND, pc held.
//         else pc_enable -> pc=pc+4. Otherwise pc held.
//   PEND: halt -> HALTED. pc_enable -> pc=pend_target, RUN.
//         pc_select/take ignored while in PEND (EX holds wrong-path work).
//   HALTED: pc, pend_target, IF/ID held at zero-flush; exit only via nRST.
//  IF/ID latch: ifid_flush -> both regs = 0; else ifid_enable -> ifid_imemload=imemload, ifid_npc=pc+4; else hold.
//   In HALTED the latch is forced to 0 regardless of enable/flush.
//  Priority when simultaneous: nRST > halt > PEND target > new take > sequential.
//  Latency: redirect visible on imemaddr one cycle after the enabling edge; no combinational path from pc_select to imemaddr.
//  PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no fault.
//  Reset asserted mid-PEND: pending target discarded; pc=PC_INIT.
// TESTING
//  1 Reset release, ihit=1, pc_enable=1 x3 -> imemaddr 0,4,8,C; ifid_npc 4,8,C.
//  2 pc_select=BEQ, z_fl=1, ex_npc=0x100, ex_imm16=0xFFFE, pc_enable=1 -> next imemaddr=0x0F8; z_fl=0 -> PC+4.
//  3 pc_select=JUMP, ex_npc=0x4000_0010, ex_jaddr=0x0000040, pc_enable=0 -> state PEND, pc held;
//    3 stall cycles with pc_select=NEXT, then pc_enable=1 -> imemaddr=0x4000_0100.
//  4 ifid_enable=1 and ifid_flush=1 same edge -> ifid_imemload=0, ifid_npc=0.
//  5 halt=1 in PEND -> imemREN=0, imemaddr frozen, IF/ID=0; later pc_enable pulses cause no change.
//  6 pc=0xFFFF_FFFC, pc_enable=1 -> imemaddr=0; nRST low mid-PEND -> imemaddr=PC_INIT, pending target dropped.

Source files
------------

// File: rtl/fetch_unit.sv
// IF stage: owns the PC and the IF/ID latch, resolves EX-stage redirects and
// holds a redirect that arrives while fetch is stalled until the stall lifts.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        pc_enable,
    input  logic        ifid_enable,
    input  logic        ifid_flush,
    input  logic [2:0]  pc_select,
    input  logic        z_fl,
    input  logic [31:0] ex_npc,
    input  logic [15:0] ex_imm16,
    input  logic [25:0] ex_jaddr,
    input  logic [31:0] ex_rs_data,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] ifid_imemload,
    output logic [31:0] ifid_npc
);

    // pc_select encoding shared with the decode/hazard logic
    localparam logic [2:0] SEL_NEXT  = 3'd0;
    localparam logic [2:0] SEL_JUMP  = 3'd1;
    localparam logic [2:0] SEL_JR    = 3'd2;
    localparam logic [2:0] SEL_BEQ   = 3'd3;
    localparam logic [2:0] SEL_BNE   = 3'd4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pend_reg, pend_next;
    logic [31:0] ifid_imemload_reg, ifid_imemload_next;
    logic [31:0] ifid_npc_reg, ifid_npc_next;
    logic        take;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // ihit only gates stalls inside the hazard unit, which folds it into pc_enable
    logic unused_ihit;
    assign unused_ihit = ihit;

    assign pc_plus4 = pc_reg + 32'd4;

    always_comb begin
        take   = 1'b0;
        target = ex_npc + {{14{ex_imm16[15]}}, ex_imm16, 2'b00};
        case (pc_select)
            SEL_JUMP: begin
                take   = 1'b1;
                target = {ex_npc[31:28], ex_jaddr, 2'b00};
            end
            SEL_JR: begin
                take   = 1'b1;
                target = ex_rs_data;
            end
            SEL_BEQ:  take = z_fl;
            SEL_BNE:  take = ~z_fl;
            SEL_NEXT: take = 1'b0;
            default:  take = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        pend_next  = pend_reg;
        case (state_reg)
            RUN: begin
                if (halt) begin
                    state_next = HALTED;
                end else if (take && pc_enable) begin
                    pc_next = target;
                end else if (take) begin
                    pend_next  = target;
                    state_next = PEND;
                end else if (pc_enable) begin
                    pc_next = pc_plus4;
                end
            end
            PEND: begin
                // EX is on the wrong path here, so its pc_select is ignored
                if (halt) begin
                    state_next = HALTED;
                end else if (pc_enable) begin
                    pc_next    = pend_reg;
                    state_next = RUN;
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // The halting edge already clears the latch so no stale instruction survives
    always_comb begin
        ifid_imemload_next = ifid_imemload_reg;
        ifid_npc_next      = ifid_npc_reg;
        if (state_reg == HALTED || halt || ifid_flush) begin
            ifid_imemload_next = 32'd0;
            ifid_npc_next      = 32'd0;
        end else if (ifid_enable) begin
            ifid_imemload_next = imemload;
            ifid_npc_next      = pc_plus4;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg         <= RUN;
            pc_reg            <= PC_INIT;
            pend_reg          <= 32'd0;
            ifid_imemload_reg <= 32'd0;
            ifid_npc_reg      <= 32'd0;
        end else begin
            state_reg         <= state_next;
            pc_reg            <= pc_next;
            pend_reg          <= pend_next;
            ifid_imemload_reg <= ifid_imemload_next;
            ifid_npc_reg      <= ifid_npc_next;
        end
    end

    assign imemaddr      = pc_reg;
    assign imemREN       = (state_reg != HALTED);
    assign ifid_imemload = ifid_imemload_reg;
    assign ifid_npc      = ifid_npc_reg;

endmodule
